// File: rtl/axi_single_beat_master.sv
// axi_single_beat_master
// Turns one load/store request into one single-beat 64-bit AXI4 transaction.
// Only one transaction is in flight at a time. Every AXI control output comes
// from a flop or from a constant, so slave timing never feeds back into this
// block combinationally. Writes present AW and W in the same cycle.
module axi_single_beat_master #(
    parameter logic [3:0] AXI_ID    = 4'h0,
    parameter logic [3:0] AXI_CACHE = 4'b0010
) (
    input  logic        clk,
    input  logic        rst,

    // core request / response port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,

    // AXI write address channel
    output logic [3:0]  m_axi_aw_id,
    output logic [63:0] m_axi_aw_addr,
    output logic [7:0]  m_axi_aw_len,
    output logic [2:0]  m_axi_aw_size,
    output logic [1:0]  m_axi_aw_burst,
    output logic [3:0]  m_axi_aw_cache,
    output logic [2:0]  m_axi_aw_prot,
    output logic [3:0]  m_axi_aw_qos,
    output logic        m_axi_aw_valid,
    input  logic        m_axi_aw_ready,

    // AXI write data channel
    output logic [63:0] m_axi_w_data,
    output logic [7:0]  m_axi_w_strb,
    output logic        m_axi_w_last,
    output logic        m_axi_w_valid,
    input  logic        m_axi_w_ready,

    // AXI write response channel
    input  logic [3:0]  m_axi_b_id,
    input  logic [1:0]  m_axi_b_resp,
    input  logic        m_axi_b_valid,
    output logic        m_axi_b_ready,

    // AXI read address channel
    output logic [3:0]  m_axi_ar_id,
    output logic [63:0] m_axi_ar_addr,
    output logic [7:0]  m_axi_ar_len,
    output logic [2:0]  m_axi_ar_size,
    output logic [1:0]  m_axi_ar_burst,
    output logic [3:0]  m_axi_ar_cache,
    output logic [2:0]  m_axi_ar_prot,
    output logic [3:0]  m_axi_ar_qos,
    output logic        m_axi_ar_valid,
    input  logic        m_axi_ar_ready,

    // AXI read data channel
    input  logic [3:0]  m_axi_r_id,
    input  logic [63:0] m_axi_r_data,
    input  logic [1:0]  m_axi_r_resp,
    input  logic        m_axi_r_last,
    input  logic        m_axi_r_valid,
    output logic        m_axi_r_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        req_ready_q, req_ready_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        ar_valid_q, ar_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        r_ready_q, r_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;

    // Per-channel "finished" terms for the write address phase: a channel
    // counts as done once its valid has dropped or it handshakes this cycle.
    logic        aw_fin;
    logic        w_fin;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        aw_fin      = !aw_valid_q || m_axi_aw_ready;
        w_fin       = !w_valid_q || m_axi_w_ready;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = S_WADDR;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = S_RADDR;
                    end
                end
            end

            S_WADDR: begin
                // Each valid drops on its own handshake; move on once both
                // have gone, whether in the same cycle or in different ones.
                if (aw_valid_q && m_axi_aw_ready) begin
                    aw_valid_d = 1'b0;
                end
                if (w_valid_q && m_axi_w_ready) begin
                    w_valid_d = 1'b0;
                end
                if (aw_fin && w_fin) begin
                    b_ready_d = 1'b1;
                    state_d   = S_WRESP;
                end
            end

            S_WRESP: begin
                if (m_axi_b_valid) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = m_axi_b_resp[1] | (m_axi_b_id != AXI_ID);
                    state_d     = S_RSP;
                end
            end

            S_RADDR: begin
                if (m_axi_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_RDATA;
                end
            end

            S_RDATA: begin
                if (m_axi_r_valid) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_r_data;
                    // SLVERR/DECERR, a missing last flag or a foreign id all
                    // mark the access as failed; the data is still returned.
                    rsp_err_d   = m_axi_r_resp[1] | ~m_axi_r_last
                                | (m_axi_r_id != AXI_ID);
                    state_d     = S_RDATA == S_RDATA ? S_RSP : S_RSP;
                end
            end

            S_RSP: begin
                // The response pulse lasts one cycle; the error flag goes
                // with it so it never lingers into the next request.
                rsp_err_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                ar_valid_d = 1'b0;
                b_ready_d  = 1'b0;
                r_ready_d  = 1'b0;
                rsp_err_d  = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; an asynchronous reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Core-side outputs
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Write address channel: address is zeroed whenever the channel is idle.
    assign m_axi_aw_id    = AXI_ID;
    assign m_axi_aw_addr  = aw_valid_q ? addr_q : '0;
    assign m_axi_aw_len   = 8'd0;
    assign m_axi_aw_size  = 3'b011;
    assign m_axi_aw_burst = 2'b01;
    assign m_axi_aw_cache = AXI_CACHE;
    assign m_axi_aw_prot  = 3'b000;
    assign m_axi_aw_qos   = 4'h0;
    assign m_axi_aw_valid = aw_valid_q;

    // Write data channel: the single beat is always the last one.
    assign m_axi_w_data  = wdata_q;
    assign m_axi_w_strb  = wstrb_q;
    assign m_axi_w_last  = w_valid_q;
    assign m_axi_w_valid = w_valid_q;

    assign m_axi_b_ready = b_ready_q;

    // Read address channel
    assign m_axi_ar_id    = AXI_ID;
    assign m_axi_ar_addr  = ar_valid_q ? addr_q : '0;
    assign m_axi_ar_len   = 8'd0;
    assign m_axi_ar_size  = 3'b011;
    assign m_axi_ar_burst = 2'b01;
    assign m_axi_ar_cache = AXI_CACHE;
    assign m_axi_ar_prot  = 3'b000;
    assign m_axi_ar_qos   = 4'h0;
    assign m_axi_ar_valid = ar_valid_q;

    assign m_axi_r_ready = r_ready_q;

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Testbench for axi_single_beat_master: a configurable AXI slave, a word
// memory reference model and a response scoreboard fed by the stimulus.
module tb_axi_single_beat_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    logic [3:0]  aw_id, ar_id, aw_cache, ar_cache, aw_qos, ar_qos;
    logic [63:0] aw_addr, ar_addr, w_data;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last;
    logic        ar_valid, ar_ready;
    logic [3:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic        b_valid, b_ready, r_valid, r_ready, r_last;
    logic [63:0] r_data;

    axi_single_beat_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_aw_id(aw_id), .m_axi_aw_addr(aw_addr), .m_axi_aw_len(aw_len),
        .m_axi_aw_size(aw_size), .m_axi_aw_burst(aw_burst), .m_axi_aw_cache(aw_cache),
        .m_axi_aw_prot(aw_prot), .m_axi_aw_qos(aw_qos),
        .m_axi_aw_valid(aw_valid), .m_axi_aw_ready(aw_ready),
        .m_axi_w_data(w_data), .m_axi_w_strb(w_strb), .m_axi_w_last(w_last),
        .m_axi_w_valid(w_valid), .m_axi_w_ready(w_ready),
        .m_axi_b_id(b_id), .m_axi_b_resp(b_resp),
        .m_axi_b_valid(b_valid), .m_axi_b_ready(b_ready),
        .m_axi_ar_id(ar_id), .m_axi_ar_addr(ar_addr), .m_axi_ar_len(ar_len),
        .m_axi_ar_size(ar_size), .m_axi_ar_burst(ar_burst), .m_axi_ar_cache(ar_cache),
        .m_axi_ar_prot(ar_prot), .m_axi_ar_qos(ar_qos),
        .m_axi_ar_valid(ar_valid), .m_axi_ar_ready(ar_ready),
        .m_axi_r_id(r_id), .m_axi_r_data(r_data), .m_axi_r_resp(r_resp),
        .m_axi_r_last(r_last), .m_axi_r_valid(r_valid), .m_axi_r_ready(r_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- slave configuration (set per transaction) ----------------
    int         cfg_a_wait = 0;   // aw or ar ready delay
    int         cfg_w_wait = 0;
    int         cfg_x_wait = 0;   // b or r valid delay
    logic [1:0] cfg_resp = 2'b00;
    logic [3:0] cfg_id   = 4'h0;
    logic       cfg_last = 1'b1;

    // ---------------- AXI slave model ----------------
    bit [63:0]   slave_mem [16];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [63:0] s_awaddr, s_wdata, s_raddr;
    logic [7:0]  s_wstrb;
    logic [63:0] wr_addr_now, wr_data_now, wr_mask;
    logic [7:0]  wr_strb_now;

    assign aw_ready = aw_valid && (aw_cnt >= cfg_a_wait);
    assign w_ready  = w_valid && (w_cnt >= cfg_w_wait);
    assign ar_ready = ar_valid && (ar_cnt >= cfg_a_wait);
    assign b_valid  = b_pend && (b_cnt >= cfg_x_wait);
    assign r_valid  = r_pend && (r_cnt >= cfg_x_wait);
    assign b_id     = cfg_id;
    assign b_resp   = cfg_resp;
    assign r_id     = cfg_id;
    assign r_resp   = cfg_resp;
    assign r_last   = cfg_last;
    assign r_data   = slave_mem[s_raddr[6:3]];

    assign wr_addr_now = (aw_valid && aw_ready) ? aw_addr : s_awaddr;
    assign wr_data_now = (w_valid && w_ready) ? w_data : s_wdata;
    assign wr_strb_now = (w_valid && w_ready) ? w_strb : s_wstrb;
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < 8; i++) wr_mask[i*8 +: 8] = {8{wr_strb_now[i]}};
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_raddr <= '0;
        end else begin
            aw_cnt <= (aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
            w_cnt  <= (w_valid && !w_ready) ? w_cnt + 1 : 0;
            ar_cnt <= (ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
            if (aw_valid && aw_ready) begin aw_got <= 1'b1; s_awaddr <= aw_addr; end
            if (w_valid && w_ready) begin w_got <= 1'b1; s_wdata <= w_data; s_wstrb <= w_strb; end
            if ((aw_got || (aw_valid && aw_ready)) && (w_got || (w_valid && w_ready))
                && ((aw_valid && aw_ready) || (w_valid && w_ready))) begin
                slave_mem[wr_addr_now[6:3]] <= (slave_mem[wr_addr_now[6:3]] & ~wr_mask)
                                             | (wr_data_now & wr_mask);
                aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end else if (b_pend) begin
                if (b_valid && b_ready) b_pend <= 1'b0;
                else if (!b_valid) b_cnt <= b_cnt + 1;
            end
            if (ar_valid && ar_ready) begin r_pend <= 1'b1; r_cnt <= 0; s_raddr <= ar_addr; end
            else if (r_pend) begin
                if (r_valid && r_ready) r_pend <= 1'b0;
                else if (!r_valid) r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
        bit          err;
        int          due;
    } exp_t;
    exp_t      exp_q[$];
    bit [63:0] model_mem [16];

    // req_ready reference: busy from the accept edge until the edge after the response.
    bit busy;
    always @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else if (req_valid && req_ready) busy <= 1'b1;
        else if (rsp_valid) busy <= 1'b0;
    end

    // Monitor: checks AXI beats, channel stability and every response pulse.
    int          n_b_hs = 0, n_wr_rsp = 0;
    logic        pa_wait, pw_wait, pr_wait, pa_hs, pw_hs, pr_hs;
    logic [63:0] pa_addr, pw_data, pr_addr;
    always @(negedge clk) begin
        if (rst) begin
            pa_wait = 0; pw_wait = 0; pr_wait = 0; pa_hs = 0; pw_hs = 0; pr_hs = 0;
        end else begin
            chk("req_ready", {127'd0, req_ready}, {127'd0, !busy});
            if (req_ready)
                chk("idle_outputs", {aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_valid, aw_addr, ar_addr},
                    {6'd0, 64'd0, 64'd0});
            if (pa_wait) chk("aw_stable", {aw_valid, aw_addr}, {1'b1, pa_addr});
            if (pw_wait) chk("w_stable", {w_valid, w_data}, {1'b1, pw_data});
            if (pr_wait) chk("ar_stable", {ar_valid, ar_addr}, {1'b1, pr_addr});
            if (pa_hs) chk("aw_drop", {127'd0, aw_valid}, 128'd0);
            if (pw_hs) chk("w_drop", {127'd0, w_valid}, 128'd0);
            if (pr_hs) chk("ar_drop", {127'd0, ar_valid}, 128'd0);
            if (exp_q.size() != 0) begin
                if (aw_valid && aw_ready)
                    chk("aw_beat", {aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_cache, aw_prot, aw_qos},
                        {exp_q[0].addr, 4'h0, 8'd0, 3'd3, 2'd1, 4'd2, 3'd0, 4'd0});
                if (w_valid && w_ready)
                    chk("w_beat", {w_data, w_strb, w_last}, {exp_q[0].wdata, exp_q[0].wstrb, 1'b1});
                if (ar_valid && ar_ready)
                    chk("ar_beat", {ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_cache, ar_prot, ar_qos},
                        {exp_q[0].addr, 4'h0, 8'd0, 3'd3, 2'd1, 4'd2, 3'd0, 4'd0});
            end
            if (b_valid && b_ready) n_b_hs++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_cycle", 128'(cyc), 128'(e.due));
                    chk("rsp_rdata", {64'd0, rsp_rdata}, {64'd0, e.rdata});
                    chk("rsp_err", {127'd0, rsp_err}, {127'd0, e.err});
                    if (e.we) begin
                        n_wr_rsp++;
                        chk("b_count", 128'(n_b_hs), 128'(n_wr_rsp));
                    end
                    $display("txn %s addr=%h rdata=%h err=%0d cycle=%0d",
                             e.we ? "WR" : "RD", e.addr, rsp_rdata, rsp_err, cyc);
                end
            end
            pa_wait = aw_valid && !aw_ready; pa_addr = aw_addr; pa_hs = aw_valid && aw_ready;
            pw_wait = w_valid && !w_ready;   pw_data = w_data;  pw_hs = w_valid && w_ready;
            pr_wait = ar_valid && !ar_ready; pr_addr = ar_addr; pr_hs = ar_valid && ar_ready;
        end
    end

    // ---------------- stimulus ----------------
    int last_accept = 0;

    // Issues one request (called away from the rising edge). For reads the
    // two delays are the AR ready delay and the R valid delay.
    task automatic issue(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] strb, input int a_wait, input int w_wait, input int x_wait,
                         input logic [1:0] resp, input logic [3:0] id, input logic last, input bit hold);
        exp_t e;
        int   n;
        cfg_a_wait = a_wait; cfg_w_wait = w_wait; cfg_x_wait = x_wait;
        cfg_resp = resp; cfg_id = id; cfg_last = last;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        last_accept = cyc;
        e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = strb;
        if (we) begin
            for (int b = 0; b < 8; b++)
                if (strb[b]) model_mem[addr[6:3]][b*8 +: 8] = wdata[b*8 +: 8];
            e.rdata = 64'd0;
            e.err   = resp[1] || (id != 4'h0);
            e.due   = cyc + 3 + ((a_wait > w_wait) ? a_wait : w_wait) + x_wait;
        end else begin
            e.rdata = model_mem[addr[6:3]];
            e.err   = resp[1] || (id != 4'h0) || !last;
            e.due   = cyc + 3 + a_wait + x_wait;
        end
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        if (!hold) begin
            req_valid = 1'b0;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            req_wstrb = 8'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int n, prev;
        #1;
        chk("reset_state", {req_ready, rsp_valid, rsp_err, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_rdata, aw_addr},
            {8'b1000_0000, 64'd0, 64'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: fully ready write, zero-wait response
        issue(1'b1, 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 0, 2'b00, 4'h0, 1'b1, 1'b0);
        wait_idle();
        // 2: read back with five R wait cycles
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 0, 5, 2'b00, 4'h0, 1'b1, 1'b0);
        wait_idle();
        // 3: AW accepted two cycles before W, partial strobe
        issue(1'b1, 64'h8000_0018, 64'h1122_3344_5566_7788, 8'h0F, 0, 2, 1, 2'b01, 4'h0, 1'b1, 1'b0);
        wait_idle();
        // 3b: W accepted before AW
        issue(1'b1, 64'h8000_0018, 64'hAABB_CCDD_EEFF_0011, 8'hF0, 3, 0, 0, 2'b00, 4'h0, 1'b1, 1'b0);
        wait_idle();
        // 4: SLVERR read, then write with a foreign B id
        issue(1'b0, 64'h8000_0018, 64'd0, 8'h00, 1, 0, 0, 2'b10, 4'h0, 1'b1, 1'b0);
        wait_idle();
        issue(1'b1, 64'h8000_0020, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, 0, 0, 2, 2'b00, 4'h3, 1'b1, 1'b0);
        wait_idle();
        // read with last flag missing
        issue(1'b0, 64'h8000_0020, 64'd0, 8'h00, 0, 0, 0, 2'b00, 4'h0, 1'b0, 1'b0);
        wait_idle();

        // 5: reset while waiting for read data
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 0, 20, 2'b00, 4'h0, 1'b1, 1'b0);
        n = 0;
        while (!r_ready && n < 50) begin @(negedge clk); n++; end
        chk("reached_rdata", {127'd0, r_ready}, {127'd0, 1'b1});
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {req_ready, rsp_valid, rsp_err, aw_valid, w_valid, ar_valid, b_ready, r_ready, rsp_rdata, ar_addr},
            {8'b1000_0000, 64'd0, 64'd0});
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 0, 0, 2'b00, 4'h0, 1'b1, 1'b0);
        wait_idle();

        // 6: back-to-back reads with req_valid held high
        issue(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, 0, 0, 2'b00, 4'h0, 1'b1, 1'b1);
        for (int k = 1; k < 4; k++) begin
            prev = last_accept;
            issue(1'b0, 64'h8000_0010 + 64'(k * 8), 64'd0, 8'h00, 0, 0, 0, 2'b00, 4'h0, 1'b1, (k != 3));
            chk("b2b_spacing", 128'(last_accept - prev), 128'd4);
        end
        wait_idle();

        // random traffic over sixteen words
        for (int t = 0; t < 40; t++) begin
            bit          we;
            logic [63:0] a;
            logic [1:0]  rs;
            logic [3:0]  id;
            logic        lst;
            we  = 1'($urandom_range(0, 1));
            a   = 64'h8000_0000 + 64'($urandom_range(0, 15) * 8);
            rs  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            id  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            lst = ($urandom_range(0, 7) != 0);
            issue(we, a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), rs, id, lst, 1'b0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
